axi4l_cmd_master: RTL and testbench
===================================

Name: axi4l_cmd_master

Overview:
AXI4-Lite master that converts a simple valid/ready command stream into single AXI4-Lite read or write transactions. It drives the SLAVE side of uart_wrapper through axi4l_if.MASTER, one transaction outstanding at a time. It returns data, response code and a timeout flag on a response stream. It lets a CPU-less controller (bring-up sequencer or test fabric) program and poll the UART.

Parameters:
ADDR_WIDTH, 32, AXI and command address width
DATA_WIDTH, 32, AXI and command data width; must be 32 or 64
BASE_OFFSET, 32'h8000_0000, added (modulo 2^ADDR_WIDTH) to cmd_addr to form AWADDR/ARADDR
TIMEOUT_CYCLES, 1024, maximum cycles waited for BVALID/RVALID after address/data acceptance; 0 disables the timeout

Ports:
clk  in  1  single clock for all logic and the AXI interface
rstn  in  1  asynchronous assert, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  byte address, relative to BASE_OFFSET
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  DATA_WIDTH/8  write strobes
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
rsp_resp  out  2  axi4l_resp_t (OKAY/EXOKAY/SLVERR/DECERR); SLVERR on timeout
rsp_timeout  out  1  response produced by timeout
intf  master  axi4l_if.MASTER  AW/W/B/AR/R channels

Behaviour:
- Reset (rstn low, asynchronous) sets these outputs to 0: cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, AWVALID, WVALID, BREADY, ARVALID and RREADY. AXI address, data and strobe outputs also reset to 0. The state machine enters IDLE. Reset may be released asynchronously; logic leaves reset on the first clk edge after release.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP, DRAIN.
- IDLE: cmd_ready=1. On accept, register the command.
  - Write: go to WR and assert AWVALID and WVALID on the next cycle. AWADDR=BASE_OFFSET+cmd_addr, WDATA=cmd_wdata, WSTRB=cmd_wstrb, AWPROT=ARPROT=3'b000.
  - Read: go to RD_ADDR and assert ARVALID.
- WR: AW and W complete independently.
  - Each VALID drops the cycle after its own handshake and is never withdrawn before it.
  - When both have completed (either order, or the same cycle), go to WR_RESP with BREADY=1.
- WR_RESP: on BVALID&&BREADY, capture BRESP, drop BREADY, go to RSP.
- RD_ADDR: on ARVALID&&ARREADY, drop ARVALID, raise RREADY, go to RD_DATA.
- RD_DATA: on RVALID&&RREADY, capture RDATA/RRESP, drop RREADY, go to RSP.
- Minimum latency, zero-wait slave: cmd accept at cycle 0, VALID at cycle 1, handshake at cycle 1, B/R at cycle 2, rsp_valid at cycle 3.
- Timeout, when TIMEOUT_CYCLES>0:
  - The counter clears on entry to WR_RESP/RD_DATA and increments each cycle there.
  - When it reaches TIMEOUT_CYCLES with no B/R handshake, report rsp_resp=SLVERR, rsp_timeout=1, rsp_rdata=0.
  - The pending-drain flag is set; BREADY/RREADY stay high.
  - AW/W/AR waits have no timeout, because VALID may not be withdrawn.
- RSP: rsp_valid=1, holding values until rsp_ready. Then go to DRAIN if the drain flag is set, else to IDLE. rsp_valid is held indefinitely; backpressure is legal.
- DRAIN: cmd_ready=0. Keep the relevant READY high until the late B/R handshake, discard it, clear the flag, go to IDLE.
  - A late B/R arriving on the same cycle the timeout fires counts as the real response; no timeout is reported.
- cmd_ready is 0 in every state except IDLE. There is no command buffering.
- Address addition wraps modulo 2^ADDR_WIDTH; carry is discarded.

Decomposition:
- Reuse axi4l_pkg: axi4l_resp_t, plus a new state enum axi4l_cmd_state_t.
- Add constant AXI4L_PROT_DEFAULT=3'b000 to axi4l_pkg.
- Single module; the timeout counter is inline, no sub-module.

Test Plan:
- Zero-wait write: cmd_addr=0x4, wdata=0xA5, wstrb=0xF. Required: AWADDR=0x8000_0004, WDATA=0xA5 and rsp_valid at cycle 3 with resp=OKAY, timeout=0.
- Read with 5-cycle ARREADY stall and 3-cycle RVALID delay, slave returns 0xDEAD_BEEF/OKAY. Required: ARVALID held for exactly 6 cycles and rsp_rdata=0xDEAD_BEEF.
- Write with WREADY before AWREADY (W at cycle 1, AW at cycle 4), then the same-cycle case. Required: WR_RESP entered only after both handshakes; BRESP=SLVERR is propagated.
- TIMEOUT_CYCLES=16, slave never raises BVALID within 16 cycles, then raises it at cycle 40. Required: rsp SLVERR, timeout=1; cmd_ready=0 until the late B is drained, then 1.
- rsp_ready held low 10 cycles. Required: rsp stable, cmd_ready=0 throughout; the next command is accepted the cycle after the response handshake.
- rstn asserted mid-RD_DATA. Required: all VALID/READY/rsp outputs go to 0 immediately without a clk edge; after release, cmd_ready=1 on the first edge; a subsequent read to 0x0 completes normally.

Source files
------------

// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types: response codes, command-master state encoding and default PROT.
package axi4l_pkg;

    typedef enum logic [1:0] {
        AXI4L_OKAY   = 2'b00,
        AXI4L_EXOKAY = 2'b01,
        AXI4L_SLVERR = 2'b10,
        AXI4L_DECERR = 2'b11
    } axi4l_resp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_RSP,
        ST_DRAIN
    } axi4l_cmd_state_t;

    localparam logic [2:0] AXI4L_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite channel bundle with master and slave views.
interface axi4l_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport MASTER (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport SLAVE (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4l_cmd_master.sv
// Turns a valid/ready command stream into single AXI4-Lite transactions, one in flight,
// returning data/response/timeout on a response stream.
module axi4l_cmd_master
    import axi4l_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_OFFSET    = 'h8000_0000,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    axi4l_if.MASTER                 intf
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    axi4l_cmd_state_t        r_state;
    logic                    r_cmd_ready;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic [1:0]              r_rsp_resp;
    logic                    r_rsp_timeout;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_bready;
    logic                    r_arvalid;
    logic                    r_rready;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic                    r_drain;
    logic [CNT_W-1:0]        r_cnt;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic w_aw_done, w_w_done, w_tmo, w_late_hs;

    assign w_aw_hs   = r_awvalid & intf.awready;
    assign w_w_hs    = r_wvalid  & intf.wready;
    assign w_b_hs    = r_bready  & intf.bvalid;
    assign w_ar_hs   = r_arvalid & intf.arready;
    assign w_r_hs    = r_rready  & intf.rvalid;
    assign w_aw_done = r_aw_done | w_aw_hs;
    assign w_w_done  = r_w_done  | w_w_hs;
    assign w_tmo     = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);
    // A response that was already reported as a timeout is swallowed here.
    assign w_late_hs = r_drain & (w_b_hs | w_r_hs);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= '0;
            r_rsp_timeout <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_drain       <= 1'b0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= BASE_OFFSET + cmd_addr;
                        if (cmd_write) begin
                            r_wdata   <= cmd_wdata;
                            r_wstrb   <= cmd_wstrb;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= ST_WR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR: begin
                    if (w_aw_hs) r_awvalid <= 1'b0;
                    if (w_w_hs)  r_wvalid  <= 1'b0;
                    r_aw_done <= w_aw_done;
                    r_w_done  <= w_w_done;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (w_b_hs) begin
                        r_bready      <= 1'b0;
                        r_rsp_resp    <= intf.bresp;
                        r_rsp_rdata   <= '0;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= ST_RSP;
                    end else if (w_tmo) begin
                        r_rsp_resp    <= AXI4L_SLVERR;
                        r_rsp_rdata   <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_drain       <= 1'b1;
                        r_state       <= ST_RSP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RD_ADDR: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (w_r_hs) begin
                        r_rready      <= 1'b0;
                        r_rsp_resp    <= intf.rresp;
                        r_rsp_rdata   <= intf.rdata;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= ST_RSP;
                    end else if (w_tmo) begin
                        r_rsp_resp    <= AXI4L_SLVERR;
                        r_rsp_rdata   <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_drain       <= 1'b1;
                        r_state       <= ST_RSP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RSP: begin
                    // The late B/R may already arrive while the timeout response waits.
                    if (w_late_hs) begin
                        r_drain  <= 1'b0;
                        r_bready <= 1'b0;
                        r_rready <= 1'b0;
                    end
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (r_drain && !w_late_hs) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_cmd_ready <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_late_hs) begin
                        r_drain     <= 1'b0;
                        r_bready    <= 1'b0;
                        r_rready    <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_resp     = r_rsp_resp;
    assign rsp_timeout  = r_rsp_timeout;

    assign intf.awaddr  = r_addr;
    assign intf.awprot  = AXI4L_PROT_DEFAULT;
    assign intf.awvalid = r_awvalid;
    assign intf.wdata   = r_wdata;
    assign intf.wstrb   = r_wstrb;
    assign intf.wvalid  = r_wvalid;
    assign intf.bready  = r_bready;
    assign intf.araddr  = r_addr;
    assign intf.arprot  = AXI4L_PROT_DEFAULT;
    assign intf.arvalid = r_arvalid;
    assign intf.rready  = r_rready;

endmodule

// File: tb/tb_axi4l_cmd_master.sv
// Directed bench for axi4l_cmd_master: vector table of single transactions plus
// hand sequences for timeout/drain, response backpressure and mid-transfer reset.
`timescale 1ns/1ps
module tb_axi4l_cmd_master;

    logic        clk;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    axi4l_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    axi4l_cmd_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .BASE_OFFSET(32'h8000_0000), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .intf(axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave delay knobs, counted in cycles after the corresponding VALID/READY rises.
    int          s_aw_dly = 0, s_w_dly = 0, s_ar_dly = 0, s_b_dly = 0, s_r_dly = 0;
    logic [1:0]  s_resp   = 2'b00;
    logic [31:0] s_rdata  = 32'h0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
        logic [1:0]  sresp;
        logic [31:0] srdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic        exp_to;
        int          exp_lat;
        int          exp_vcyc;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reactive slave: each READY/VALID rises after its delay and drops after the handshake.
    initial begin
        int aw_c, w_c, ar_c, b_c, r_c;
        aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid  = 1'b0; axi.bresp  = 2'b00;
        axi.rvalid  = 1'b0; axi.rresp  = 2'b00; axi.rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (axi.awready) begin axi.awready = 1'b0; aw_c = 0; end
            else if (axi.awvalid) begin if (aw_c >= s_aw_dly) axi.awready = 1'b1; else aw_c++; end
            else aw_c = 0;
            if (axi.wready) begin axi.wready = 1'b0; w_c = 0; end
            else if (axi.wvalid) begin if (w_c >= s_w_dly) axi.wready = 1'b1; else w_c++; end
            else w_c = 0;
            if (axi.arready) begin axi.arready = 1'b0; ar_c = 0; end
            else if (axi.arvalid) begin if (ar_c >= s_ar_dly) axi.arready = 1'b1; else ar_c++; end
            else ar_c = 0;
            if (axi.bvalid) begin axi.bvalid = 1'b0; b_c = 0; end
            else if (axi.bready) begin
                if (b_c >= s_b_dly) begin axi.bvalid = 1'b1; axi.bresp = s_resp; end else b_c++;
            end else b_c = 0;
            if (axi.rvalid) begin axi.rvalid = 1'b0; r_c = 0; end
            else if (axi.rready) begin
                if (r_c >= s_r_dly) begin
                    axi.rvalid = 1'b1; axi.rresp = s_resp; axi.rdata = s_rdata;
                end else r_c++;
            end else r_c = 0;
        end
    end

    task automatic wait_cmd_ready(input string nm);
        int n;
        n = 0;
        while (!cmd_ready && n < 200) begin tick(); n++; end
        if (!cmd_ready) check({nm, "_cmd_ready_wait"}, 64'(cmd_ready), 64'd1);
    endtask

    task automatic set_slave(input vec_t v);
        s_aw_dly = v.aw_dly; s_w_dly = v.w_dly; s_ar_dly = v.ar_dly;
        s_b_dly  = v.b_dly;  s_r_dly = v.r_dly; s_resp = v.sresp; s_rdata = v.srdata;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int          cyc, vcyc, order_err;
        logic [31:0] got_addr, got_wd;
        logic [3:0]  got_ws;
        set_slave(v);
        wait_cmd_ready(nm);
        cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cyc = 1; vcyc = 0; order_err = 0;
        got_addr = '0; got_wd = '0; got_ws = '0;
        while (!rsp_valid && cyc < 200) begin
            if (v.wr && axi.awvalid) begin vcyc++; got_addr = axi.awaddr; end
            if (!v.wr && axi.arvalid) begin vcyc++; got_addr = axi.araddr; end
            if (axi.wvalid) begin got_wd = axi.wdata; got_ws = axi.wstrb; end
            if (axi.bready && (axi.awvalid || axi.wvalid)) order_err++;
            if (cmd_ready) order_err++;
            tick();
            cyc++;
        end
        check({nm, "_latency"},  64'(cyc),         64'(v.exp_lat));
        check({nm, "_addr"},     64'(got_addr),    64'(v.exp_addr));
        check({nm, "_vcycles"},  64'(vcyc),        64'(v.exp_vcyc));
        check({nm, "_rdata"},    64'(rsp_rdata),   64'(v.exp_rdata));
        check({nm, "_resp"},     64'(rsp_resp),    64'(v.exp_resp));
        check({nm, "_timeout"},  64'(rsp_timeout), 64'(v.exp_to));
        check({nm, "_order"},    64'(order_err),   64'd0);
        if (v.wr) begin
            check({nm, "_wdata"}, 64'(got_wd), 64'(v.wdata));
            check({nm, "_wstrb"}, 64'(got_ws), 64'(v.wstrb));
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({nm, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc, err;
        vec_t v;

        vecs[0] = '{1'b1, 32'h4, 32'hA5, 4'hF, 0, 0, 0, 0, 0, 2'd0, 32'h0,
                    32'h8000_0004, 32'h0, 2'd0, 1'b0, 3, 1};
        vecs[1] = '{1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 5, 0, 3, 2'd0, 32'hDEAD_BEEF,
                    32'h8000_0010, 32'hDEAD_BEEF, 2'd0, 1'b0, 11, 6};
        vecs[2] = '{1'b1, 32'h20, 32'h1111_2222, 4'h3, 3, 0, 0, 0, 0, 2'd2, 32'h0,
                    32'h8000_0020, 32'h0, 2'd2, 1'b0, 6, 4};
        vecs[3] = '{1'b1, 32'h24, 32'h3333_4444, 4'hC, 2, 2, 0, 1, 0, 2'd2, 32'h0,
                    32'h8000_0024, 32'h0, 2'd2, 1'b0, 6, 3};
        vecs[4] = '{1'b1, 32'h28, 32'h5555_6666, 4'h1, 0, 4, 0, 0, 0, 2'd0, 32'h0,
                    32'h8000_0028, 32'h0, 2'd0, 1'b0, 7, 1};
        vecs[5] = '{1'b1, 32'h8000_0008, 32'h7777_8888, 4'hF, 0, 0, 0, 0, 0, 2'd1, 32'h0,
                    32'h0000_0008, 32'h0, 2'd1, 1'b0, 3, 1};
        vecs[6] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'd3, 32'h1234_5678,
                    32'h7FFF_FFFC, 32'h1234_5678, 2'd3, 1'b0, 3, 1};
        vecs[7] = '{1'b1, 32'h30, 32'h9, 4'hF, 0, 0, 0, 14, 0, 2'd0, 32'h0,
                    32'h8000_0030, 32'h0, 2'd0, 1'b0, 17, 1};
        vecs[8] = '{1'b1, 32'h34, 32'hA, 4'hF, 0, 0, 0, 15, 0, 2'd1, 32'h0,
                    32'h8000_0034, 32'h0, 2'd1, 1'b0, 18, 1};
        vecs[9] = '{1'b0, 32'h38, 32'h0, 4'h0, 0, 0, 0, 0, 15, 2'd0, 32'hCAFE_0001,
                    32'h8000_0038, 32'hCAFE_0001, 2'd0, 1'b0, 18, 1};

        rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        #12;
        check("reset_outputs",
              64'({cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, axi.awvalid,
                   axi.wvalid, axi.bready, axi.arvalid, axi.rready, axi.awaddr, axi.wdata, axi.wstrb}),
              64'd0);
        tick();
        rstn = 1'b1;
        tick();
        check("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Timeout with a B that only shows up at cycle 40, which must be drained.
        v = vecs[0];
        v.addr = 32'h50; v.b_dly = 38; v.sresp = 2'd0;
        set_slave(v);
        wait_cmd_ready("tmo");
        cmd_write = 1'b1; cmd_addr = 32'h50; cmd_wdata = 32'h5A; cmd_wstrb = 4'hF;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 100) begin tick(); cyc++; end
        check("tmo_latency", 64'(cyc), 64'd18);
        check("tmo_resp", 64'(rsp_resp), 64'd2);
        check("tmo_flag", 64'(rsp_timeout), 64'd1);
        check("tmo_rdata", 64'(rsp_rdata), 64'd0);
        check("tmo_bready_held", 64'(axi.bready), 64'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        cyc++;
        err = 0;
        while (!cmd_ready && cyc < 100) begin
            if (rsp_valid) err++;
            tick();
            cyc++;
        end
        check("tmo_drain_release_cycle", 64'(cyc), 64'd41);
        check("tmo_drain_no_extra_rsp", 64'(err), 64'd0);
        check("tmo_bready_dropped", 64'(axi.bready), 64'd0);

        // Response backpressure for 10 cycles, then back-to-back next command.
        v = vecs[6];
        v.sresp = 2'd0; v.srdata = 32'hABCD_0123;
        set_slave(v);
        wait_cmd_ready("bp");
        cmd_write = 1'b0; cmd_addr = 32'h40; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 100) begin tick(); cyc++; end
        check("bp_latency", 64'(cyc), 64'd3);
        err = 0;
        for (int k = 0; k < 10; k++) begin
            if (!rsp_valid || rsp_rdata !== 32'hABCD_0123 || rsp_resp !== 2'd0 || cmd_ready) err++;
            tick();
        end
        check("bp_hold_stable", 64'(err), 64'd0);
        set_slave(vecs[0]);
        cmd_write = 1'b1; cmd_addr = 32'h44; cmd_wdata = 32'h44; cmd_wstrb = 4'hF;
        cmd_valid = 1'b1; rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_rsp_dropped", 64'(rsp_valid), 64'd0);
        check("bp_cmd_ready_next", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
        check("bp_next_accepted", 64'({cmd_ready, axi.awvalid}), 64'b01);
        cyc = 0;
        while (!rsp_valid && cyc < 100) begin tick(); cyc++; end
        check("bp_next_resp", 64'({rsp_valid, rsp_resp}), 64'b100);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Asynchronous reset while waiting in RD_DATA.
        v = vecs[6];
        v.r_dly = 50;
        set_slave(v);
        wait_cmd_ready("rst");
        cmd_write = 1'b0; cmd_addr = 32'h60; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cyc = 0;
        while (!axi.rready && cyc < 100) begin tick(); cyc++; end
        tick();
        #3;
        rstn = 1'b0;
        #1;
        check("rst_async_outputs",
              64'({cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, axi.awvalid,
                   axi.wvalid, axi.bready, axi.arvalid, axi.rready}),
              64'd0);
        @(posedge clk);
        @(posedge clk);
        #4;
        rstn = 1'b1;
        #1;
        check("rst_release_before_edge", 64'(cmd_ready), 64'd0);
        tick();
        check("rst_first_edge_cmd_ready", 64'(cmd_ready), 64'd1);
        v = vecs[6];
        v.addr = 32'h0; v.exp_addr = 32'h8000_0000;
        v.sresp = 2'd0; v.exp_resp = 2'd0; v.srdata = 32'h0BAD_F00D; v.exp_rdata = 32'h0BAD_F00D;
        run_vec(v, "rst_read0");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
